spi_slave_rx: RTL and testbench

// - SPI mode-0 slave front end: brings SCK/CS_N/MOSI from the pad domain into clk_in,

---
 rtl/spi_slave_rx_pkg.sv | 10 +
 rtl/spi_slave_rx_sync_ff.sv | 24 ++
 rtl/spi_slave_rx.sv | 139 +++++++++++++
 tb/tb_spi_slave_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_rx_pkg.sv
// Shared constants and state encoding for the SPI mode-0 slave receive front end.
package spi_slave_rx_pkg;
  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/spi_slave_rx_sync_ff.sv
// Multi-flop synchroniser for one asynchronous pad input, with a selectable reset level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: synchronises SCK/CS_N/MOSI into clk_in, deserialises MOSI bytes
// and shifts a reply byte out on MISO. SCK is only ever sampled as data.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                spi_sck_in,
  input  logic                spi_cs_n_in,
  input  logic                spi_mosi_in,
  output logic                spi_miso_out,
  input  logic [SPI_BITS-1:0] tx_data_in,
  output logic [SPI_BITS-1:0] data_out,
  output logic                data_valid_out,
  output logic                transaction_valid_out
);

  logic w_sck_sync, w_cs_n_sync, w_mosi_sync;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .i_d(spi_sck_in),  .o_q(w_sck_sync));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .i_d(spi_cs_n_in), .o_q(w_cs_n_sync));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .i_d(spi_mosi_in), .o_q(w_mosi_sync));

  // All three lines get the same extra stage so MOSI stays aligned with SCK.
  logic r_sck_s, r_cs_n_s, r_mosi_s, r_sck_prev, r_cs_n_prev;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sck_s     <= 1'b0;
      r_cs_n_s    <= 1'b1;
      r_mosi_s    <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_cs_n_prev <= 1'b1;
    end else begin
      r_sck_s     <= w_sck_sync;
      r_cs_n_s    <= w_cs_n_sync;
      r_mosi_s    <= w_mosi_sync;
      r_sck_prev  <= r_sck_s;
      r_cs_n_prev <= r_cs_n_s;
    end
  end

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  assign w_sck_rise =  r_sck_s  & ~r_sck_prev;
  assign w_sck_fall = ~r_sck_s  &  r_sck_prev;
  assign w_cs_rise  =  r_cs_n_s & ~r_cs_n_prev;
  assign w_cs_fall  = ~r_cs_n_s &  r_cs_n_prev;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [SPI_BITS-1:0]  r_rx_shift, r_tx_shift, r_data;
  logic                 r_dvalid, r_tvalid;
  logic                 w_clr_cnt, w_load_tx, w_shift_rx, w_shift_tx;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A CS rise takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_clr_cnt    = 1'b0;
    w_load_tx    = 1'b0;
    w_shift_rx   = 1'b0;
    w_shift_tx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ST_ACTIVE;
          w_clr_cnt    = 1'b1;
          w_load_tx    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
          w_clr_cnt    = 1'b1;
        end else begin
          w_shift_rx = w_sck_rise;
          if (w_sck_fall) begin
            if (r_bit_cnt == '0) w_load_tx  = 1'b1;
            else                 w_shift_tx = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  logic [SPI_BITS-1:0] w_rx_next, w_tx_next;
  logic                w_tx_bit;
  assign w_rx_next = MSB_FIRST ? {r_rx_shift[SPI_BITS-2:0], r_mosi_s}
                               : {r_mosi_s, r_rx_shift[SPI_BITS-1:1]};
  assign w_tx_next = MSB_FIRST ? {r_tx_shift[SPI_BITS-2:0], 1'b0}
                               : {1'b0, r_tx_shift[SPI_BITS-1:1]};
  assign w_tx_bit  = MSB_FIRST ? r_tx_shift[SPI_BITS-1] : r_tx_shift[0];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_data     <= '0;
      r_dvalid   <= 1'b0;
      r_tvalid   <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_tvalid <= ~r_cs_n_s;
      if (w_clr_cnt) begin
        r_bit_cnt <= '0;
      end else if (w_shift_rx) begin
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        r_rx_shift <= w_rx_next;
        if (r_bit_cnt == CNT_W'(SPI_BITS - 1)) begin
          r_data   <= w_rx_next;
          r_dvalid <= 1'b1;
        end
      end
      if (w_load_tx)       r_tx_shift <= tx_data_in;
      else if (w_shift_tx) r_tx_shift <= w_tx_next;
    end
  end

  assign spi_miso_out          = (r_state == ST_ACTIVE) ? w_tx_bit : 1'b0;
  assign data_out              = r_data;
  assign data_valid_out        = r_dvalid;
  assign transaction_valid_out = r_tvalid;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an MSB-first and an LSB-first instance share SCK/MOSI,
// each with its own chip select; received bytes are checked against a scoreboard.
module tb_spi_slave_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic       clk = 1'b0;
  logic       rst_n, sck, mosi, cs0_n, cs1_n;
  logic [7:0] tx_data;
  logic       miso0, dv0, tv0, miso1, dv1, tv1;
  logic [7:0] data0, data1;

  always #5 clk = ~clk;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES), .MSB_FIRST(1'b1)) u_dut0 (
    .clk_in(clk), .reset_n_in(rst_n), .spi_sck_in(sck), .spi_cs_n_in(cs0_n),
    .spi_mosi_in(mosi), .spi_miso_out(miso0), .tx_data_in(tx_data),
    .data_out(data0), .data_valid_out(dv0), .transaction_valid_out(tv0));

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES), .MSB_FIRST(1'b0)) u_dut1 (
    .clk_in(clk), .reset_n_in(rst_n), .spi_sck_in(sck), .spi_cs_n_in(cs1_n),
    .spi_mosi_in(mosi), .spi_miso_out(miso1), .tx_data_in(tx_data),
    .data_out(data1), .data_valid_out(dv1), .transaction_valid_out(tv1));

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_rise_cyc = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] e0, e1, rd, rd_dummy;
  logic       dv0_d = 1'b0;
  logic       dv1_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every data_valid_out pulse must match the next expected byte.
  always @(posedge clk) begin
    #1;
    if (dv0) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse0: data_out=%h, no byte expected", data0);
      end else begin
        e0 = exp0.pop_front();
        if (data0 !== e0) begin
          errors++;
          $display("FAIL data0: got %h expected %h", data0, e0);
        end
      end
      checks++;
      if (cyc - last_rise_cyc != SYNC_STAGES + 2) begin
        errors++;
        $display("FAIL latency0: got %0d clk expected %0d", cyc - last_rise_cyc, SYNC_STAGES + 2);
      end
      checks++;
      if (dv0_d !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width0: valid high on consecutive cycles");
      end
    end
    if (dv1) begin
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse1: data_out=%h, no byte expected", data1);
      end else begin
        e1 = exp1.pop_front();
        if (data1 !== e1) begin
          errors++;
          $display("FAIL data1: got %h expected %h", data1, e1);
        end
      end
      checks++;
      if (cyc - last_rise_cyc != SYNC_STAGES + 2) begin
        errors++;
        $display("FAIL latency1: got %0d clk expected %0d", cyc - last_rise_cyc, SYNC_STAGES + 2);
      end
    end
    dv0_d = dv0;
    dv1_d = dv1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input bit sel);
    @(negedge clk);
    if (sel) cs1_n = 1'b0; else cs0_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic cs_high(input bit sel);
    wait_clks(HALF);
    if (sel) cs1_n = 1'b1; else cs0_n = 1'b1;
    wait_clks(8);
  endtask

  // Mode-0 master: data set while SCK low, MISO sampled just before the rise.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit lsb_first,
                      input logic [7:0] next_tx, output logic [7:0] rd_o);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = lsb_first ? b[i] : b[7-i];
      wait_clks(HALF);
      r = {r[6:0], miso0 | miso1};
      sck = 1'b1;
      last_rise_cyc = cyc;
      if (i == nbits - 1) tx_data = next_tx;
      wait_clks(HALF);
      sck = 1'b0;
    end
    rd_o = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1; tx_data = 8'h00;
    wait_clks(3);
    checks++;
    if ({data0, dv0, tv0, miso0} !== 11'h0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b/%b/%b expected 00/0/0/0", data0, dv0, tv0, miso0);
    end
    rst_n = 1'b1;
    wait_clks(4);
    cs_low(1'b0);
    exp0.push_back(8'h3C);
    xfer(8'h3C, 8, 1'b0, tx_data, rd_dummy);
    cs_high(1'b0);
    checks++;
    if (data0 !== 8'h3C) begin
      errors++;
      $display("FAIL pre_reset_byte: got %h expected 3c", data0);
    end
    tx_data = 8'hFF;
    cs_low(1'b0);
    xfer(8'hFF, 4, 1'b0, tx_data, rd_dummy);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data0, dv0, tv0, miso0} !== 11'h0) begin
      errors++;
      $display("FAIL midbyte_reset: got %h/%b/%b/%b expected 00/0/0/0", data0, dv0, tv0, miso0);
    end
    cs0_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = 8'h00;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(4);
    cs_low(1'b0);
    exp0.push_back(8'h96);
    xfer(8'h96, 8, 1'b0, tx_data, rd_dummy);
    cs_high(1'b0);
    checks++;
    if (exp0.size() != 0 || data0 !== 8'h96) begin
      errors++;
      $display("FAIL post_reset_byte: got %h pending %0d expected 96 pending 0", data0, exp0.size());
    end
  endtask

  task automatic test_single;
    checks++;
    if (tv0 !== 1'b0) begin
      errors++;
      $display("FAIL tvalid_idle: got %b expected 0", tv0);
    end
    cs_low(1'b0);
    checks++;
    if (tv0 !== 1'b1) begin
      errors++;
      $display("FAIL tvalid_active: got %b expected 1", tv0);
    end
    exp0.push_back(8'hA5);
    xfer(8'hA5, 8, 1'b0, tx_data, rd_dummy);
    checks++;
    if (tv0 !== 1'b1) begin
      errors++;
      $display("FAIL tvalid_span: got %b expected 1", tv0);
    end
    cs_high(1'b0);
    checks++;
    if (tv0 !== 1'b0 || exp0.size() != 0) begin
      errors++;
      $display("FAIL single_end: tvalid %b pending %0d expected 0 and 0", tv0, exp0.size());
    end
    checks++;
    if (data0 !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got %h expected a5", data0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3];
    seq[0] = 8'h01; seq[1] = 8'h34; seq[2] = 8'hBE;
    cs_low(1'b0);
    for (int k = 0; k < 3; k++) begin
      exp0.push_back(seq[k]);
      xfer(seq[k], 8, 1'b0, tx_data, rd_dummy);
    end
    cs_high(1'b0);
    checks++;
    if (exp0.size() != 0 || data0 !== 8'hBE) begin
      errors++;
      $display("FAIL back_to_back: got %h pending %0d expected be pending 0", data0, exp0.size());
    end
  endtask

  task automatic test_miso;
    tx_data = 8'hC3;
    cs_low(1'b0);
    exp0.push_back(8'h11);
    xfer(8'h11, 8, 1'b0, 8'h5A, rd);
    checks++;
    if (rd !== 8'hC3) begin
      errors++;
      $display("FAIL miso_byte0: got %h expected c3", rd);
    end
    exp0.push_back(8'h22);
    xfer(8'h22, 8, 1'b0, 8'h00, rd);
    checks++;
    if (rd !== 8'h5A) begin
      errors++;
      $display("FAIL miso_byte1: got %h expected 5a", rd);
    end
    cs_high(1'b0);
    checks++;
    if (miso0 !== 1'b0) begin
      errors++;
      $display("FAIL miso_idle: got %b expected 0", miso0);
    end
  endtask

  task automatic test_abort;
    cs_low(1'b0);
    xfer(8'hFF, 5, 1'b0, tx_data, rd_dummy);
    cs_high(1'b0);
    checks++;
    if (data0 !== 8'h22 || exp0.size() != 0) begin
      errors++;
      $display("FAIL abort: got %h pending %0d expected 22 pending 0", data0, exp0.size());
    end
    cs_low(1'b0);
    exp0.push_back(8'h0F);
    xfer(8'h0F, 8, 1'b0, tx_data, rd_dummy);
    cs_high(1'b0);
    checks++;
    if (data0 !== 8'h0F || exp0.size() != 0) begin
      errors++;
      $display("FAIL after_abort: got %h pending %0d expected 0f pending 0", data0, exp0.size());
    end
  endtask

  task automatic test_lsb_first;
    checks++;
    if (data1 !== 8'h00 || tv1 !== 1'b0) begin
      errors++;
      $display("FAIL cs_high_ignored: got %h/%b expected 00/0", data1, tv1);
    end
    cs_low(1'b1);
    exp1.push_back(8'h80);
    xfer(8'h80, 8, 1'b1, tx_data, rd_dummy);
    cs_high(1'b1);
    checks++;
    if (data1 !== 8'h80 || exp1.size() != 0) begin
      errors++;
      $display("FAIL lsb_first: got %h pending %0d expected 80 pending 0", data1, exp1.size());
    end
    checks++;
    if (data0 !== 8'h0F) begin
      errors++;
      $display("FAIL msb_dut_ignored: got %h expected 0f", data0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_miso();
    test_abort();
    test_lsb_first();
    wait_clks(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
